// File: rtl/lcd_timing_pkg.sv
// -----------------------------------------------------------------------------
// lcd_timing_pkg
// Shared definitions for the 480x272 RGB LCD timing generator:
//   - default active/porch/sync sizes for the Tang Nano 9K panel
//   - FSM state encoding (WAIT_LOCK, RUN)
//   - RGB565 colour-bar constants and a bar-index -> colour lookup
// Optional feature macro used by the top: LCD_TIMING_TEST_PATTERN_EN.
// -----------------------------------------------------------------------------
package lcd_timing_pkg;

    // Horizontal timing in pixel clocks
    localparam int H_ACTIVE_DEF = 480;
    localparam int H_FP_DEF     = 2;
    localparam int H_SYNC_DEF   = 41;
    localparam int H_BP_DEF     = 2;

    // Vertical timing in lines
    localparam int V_ACTIVE_DEF = 272;
    localparam int V_FP_DEF     = 2;
    localparam int V_SYNC_DEF   = 10;
    localparam int V_BP_DEF     = 2;

    typedef enum logic {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } state_e;

    // RGB565 colour bars, left to right
    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lock_sync.sv
// -----------------------------------------------------------------------------
// lock_sync
// Two-flop synchronizer bringing the PLL lock flag into the pixel clock domain.
// Ports:
//   clk_i   in  pixel clock
//   rst_i   in  asynchronous active-high reset (clears both flops to 0)
//   async_i in  asynchronous level to synchronize
//   sync_o  out synchronized level, two clocks behind async_i
// -----------------------------------------------------------------------------
module lock_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/lcd_timing_gen.sv
// -----------------------------------------------------------------------------
// lcd_timing_gen
// Raster timing for the 480x272 RGB LCD in the 9 MHz pixel clock domain.
// Counters run only while the synchronized PLL lock is high; losing lock
// clears them so a re-lock always restarts at the top of a frame.
//
// Pipeline:
//   counters -> request stage (out_req/out_x/out_y/out_frame_start)
//            -> output stage  (out_de/out_hsync/out_vsync[/out_rgb])
// The request stage leads DE by one clock so a registered framebuffer read
// issued on out_req returns data aligned with out_de.
//
// Ports:
//   in_clk          in   pixel clock
//   in_rst          in   asynchronous active-high reset
//   in_clk_lock     in   PLL lock, asynchronous to in_clk
//   out_req         out  pixel request, one clock ahead of out_de
//   out_x / out_y   out  requested pixel coordinate (0 when out_req low)
//   out_de          out  panel data enable
//   out_hsync       out  horizontal sync (polarity from SYNC_ACTIVE_LOW)
//   out_vsync       out  vertical sync   (polarity from SYNC_ACTIVE_LOW)
//   out_frame_start out  one-cycle pulse with the request for pixel (0,0)
//   out_rgb         out  RGB565 colour bars, only with LCD_TIMING_TEST_PATTERN_EN
// -----------------------------------------------------------------------------
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE        = H_ACTIVE_DEF,
    parameter int H_FP            = H_FP_DEF,
    parameter int H_SYNC          = H_SYNC_DEF,
    parameter int H_BP            = H_BP_DEF,
    parameter int V_ACTIVE        = V_ACTIVE_DEF,
    parameter int V_FP            = V_FP_DEF,
    parameter int V_SYNC          = V_SYNC_DEF,
    parameter int V_BP            = V_BP_DEF,
    parameter int SYNC_ACTIVE_LOW = 1,
    localparam int H_TOTAL        = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL        = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW             = $clog2(H_TOTAL),
    localparam int VW             = $clog2(V_TOTAL)
) (
    input  logic          in_clk,
    input  logic          in_rst,
    input  logic          in_clk_lock,
    output logic          out_req,
    output logic [HW-1:0] out_x,
    output logic [VW-1:0] out_y,
    output logic          out_de,
    output logic          out_hsync,
    output logic          out_vsync,
    output logic          out_frame_start
`ifdef LCD_TIMING_TEST_PATTERN_EN
    ,
    output logic [15:0]   out_rgb
`endif
);

    // Sized decode boundaries so every compare is width-matched
    localparam logic [HW-1:0] H_ACT_C   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG_C  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END_C  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST_C  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG_C  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END_C  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST_C  = VW'(V_TOTAL - 1);

    localparam logic SYNC_ON  = (SYNC_ACTIVE_LOW == 0);
    localparam logic SYNC_OFF = !SYNC_ON;

    // ------------------------------------------------------------------
    // Lock synchronizer
    // ------------------------------------------------------------------
    logic lock_s;

    lock_sync u_lock_sync (
        .clk_i   (in_clk),
        .rst_i   (in_rst),
        .async_i (in_clk_lock),
        .sync_o  (lock_s)
    );

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    state_e state_q, state_d;
    logic   run_en;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) state_q <= WAIT_LOCK;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_LOCK: if (lock_s)  state_d = RUN;
            RUN:       if (!lock_s) state_d = WAIT_LOCK;
            default:   state_d = WAIT_LOCK;
        endcase
    end

    // Gating on lock_s as well as the state lets the counters and request
    // stage drop the same cycle lock is seen low, one clock before the FSM
    // itself leaves RUN. That keeps lock-loss to idle within four clocks.
    assign run_en = (state_q == RUN) && lock_s;

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!run_en) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_cnt_q == H_LAST_C) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + 1'b1;
        end else begin
            h_cnt_d = h_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Request stage
    // ------------------------------------------------------------------
    logic          req_q,    req_d;
    logic [HW-1:0] x_q,      x_d;
    logic [VW-1:0] y_q,      y_d;
    logic          fs_q,     fs_d;
    logic          hs_act_q, hs_act_d;
    logic          vs_act_q, vs_act_d;

    always_comb begin
        req_d    = run_en && (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
        x_d      = req_d ? h_cnt_q : '0;
        y_d      = req_d ? v_cnt_q : '0;
        fs_d     = run_en && (h_cnt_q == '0) && (v_cnt_q == '0);
        hs_act_d = run_en && (h_cnt_q >= HS_BEG_C) && (h_cnt_q < HS_END_C);
        // v_cnt only moves on the h wrap, so vsync edges land on h_cnt == 0
        vs_act_d = run_en && (v_cnt_q >= VS_BEG_C) && (v_cnt_q < VS_END_C);
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            req_q    <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            fs_q     <= 1'b0;
            hs_act_q <= 1'b0;
            vs_act_q <= 1'b0;
        end else begin
            req_q    <= req_d;
            x_q      <= x_d;
            y_q      <= y_d;
            fs_q     <= fs_d;
            hs_act_q <= hs_act_d;
            vs_act_q <= vs_act_d;
        end
    end

    // ------------------------------------------------------------------
    // Output stage: one clock behind the request stage
    // ------------------------------------------------------------------
    logic de_q,    de_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;

    always_comb begin
        de_d    = req_q;
        hsync_d = hs_act_q ? SYNC_ON : SYNC_OFF;
        vsync_d = vs_act_q ? SYNC_ON : SYNC_OFF;
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            de_q    <= 1'b0;
            hsync_q <= SYNC_OFF;
            vsync_q <= SYNC_OFF;
        end else begin
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

`ifdef LCD_TIMING_TEST_PATTERN_EN
    // ------------------------------------------------------------------
    // Colour bars, registered alongside DE and black outside active video
    // ------------------------------------------------------------------
    localparam logic [HW-1:0] BAR_W_C = HW'(H_ACTIVE / 8);
    localparam logic [HW-1:0] BAR_MAX = HW'(7);

    logic [HW-1:0] bar_full;
    logic [2:0]    bar_idx;
    logic [15:0]   rgb_q, rgb_d;

    always_comb begin
        bar_full = x_q / BAR_W_C;
        // Clamp guards non-multiple-of-8 widths from spilling past bar 7
        bar_idx  = (bar_full > BAR_MAX) ? 3'd7 : bar_full[2:0];
        rgb_d    = req_q ? bar_colour(bar_idx) : 16'h0000;
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) rgb_q <= 16'h0000;
        else        rgb_q <= rgb_d;
    end

    assign out_rgb = rgb_q;
`else
    // Test pattern disabled: no colour path is built.
`endif

    assign out_req         = req_q;
    assign out_x           = x_q;
    assign out_y           = y_q;
    assign out_frame_start = fs_q;
    assign out_de          = de_q;
    assign out_hsync       = hsync_q;
    assign out_vsync       = vsync_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_lcd_timing_gen
// Directed bench for lcd_timing_gen. Horizontal timing uses the panel
// defaults; the active height is shrunk to 40 lines so two whole frames and a
// lock-loss/re-lock fit in a short run. Frame-start pulses are scoreboarded:
// the expected cycle is queued when lock is driven and compared when the pulse
// appears. Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_lcd_timing_gen;

    localparam int V_ACT   = 40;
    localparam int H_TOT   = 480 + 2 + 41 + 2;        // 525
    localparam int V_TOT   = V_ACT + 2 + 10 + 2;      // 54
    localparam int FRAME   = H_TOT * V_TOT;           // 28350
    localparam int HW      = $clog2(H_TOT);
    localparam int VW      = $clog2(V_TOT);
    localparam int LIM     = FRAME + 2000;

    logic          clk = 1'b0;
    logic          rst;
    logic          lock;
    logic          out_req;
    logic [HW-1:0] out_x;
    logic [VW-1:0] out_y;
    logic          out_de;
    logic          out_hsync;
    logic          out_vsync;
    logic          out_frame_start;
`ifdef LCD_TIMING_TEST_PATTERN_EN
    logic [15:0]   out_rgb;
`endif

    lcd_timing_gen #(.V_ACTIVE(V_ACT)) dut (
        .in_clk          (clk),
        .in_rst          (rst),
        .in_clk_lock     (lock),
        .out_req         (out_req),
        .out_x           (out_x),
        .out_y           (out_y),
        .out_de          (out_de),
        .out_hsync       (out_hsync),
        .out_vsync       (out_vsync),
        .out_frame_start (out_frame_start)
`ifdef LCD_TIMING_TEST_PATTERN_EN
        ,
        .out_rgb         (out_rgb)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int lines  = 0;
    logic de_prev = 1'b0;
    int exp_fs[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, scoreboard frame starts, count DE lines
    task automatic tick();
        int e;
        @(negedge clk);
        cyc++;
        if (out_frame_start === 1'b1) begin
            chk("fs_expected", 32'(exp_fs.size() != 0), 1);
            if (exp_fs.size() != 0) begin
                e = exp_fs.pop_front();
                chk("fs_cycle", cyc, e);
                chk("fs_x", 32'(out_x), 0);
                chk("fs_y", 32'(out_y), 0);
            end
            lines = 0;
        end
        if (out_de === 1'b1 && de_prev === 1'b0) lines++;
        de_prev = out_de;
    endtask

    // which: 0=de 1=hsync 2=vsync 3=frame_start 4=req at (x,y), y<0 = any row
    task automatic wait_for(input int which, input logic lvl, input int x, input int y,
                            input string tag);
        logic hit;
        hit = 1'b0;
        for (int n = 0; n < LIM && !hit; n++) begin
            tick();
            case (which)
                0: hit = (out_de === lvl);
                1: hit = (out_hsync === lvl);
                2: hit = (out_vsync === lvl);
                3: hit = (out_frame_start === 1'b1);
                default: hit = (out_req === 1'b1) && (int'(out_x) == x) &&
                               (y < 0 || int'(out_y) == y);
            endcase
        end
        chk(tag, 32'(hit), 1);
    endtask

    initial begin
        int c, r0, f0, h0, v0;

        // Reset with lock already high: everything idle
        rst  = 1'b1;
        lock = 1'b1;
        repeat (3) tick();
        chk("rst_de",    32'(out_de), 0);
        chk("rst_hsync", 32'(out_hsync), 1);
        chk("rst_vsync", 32'(out_vsync), 1);
        chk("rst_req",   32'(out_req), 0);
        chk("rst_fs",    32'(out_frame_start), 0);
        chk("rst_x",     32'(out_x), 0);
        chk("rst_y",     32'(out_y), 0);
`ifdef LCD_TIMING_TEST_PATTERN_EN
        chk("rst_rgb",   32'(out_rgb), 0);
`endif
        lock = 1'b0;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("nolock_req", 32'(out_req), 0);
        chk("nolock_de",  32'(out_de), 0);

        // Lock start: frame start 4 clocks later, DE one after that
        c = cyc;
        lock = 1'b1;
        exp_fs.push_back(c + 4);
        exp_fs.push_back(c + 4 + FRAME);
        repeat (4) tick();
        chk("start_req", 32'(out_req), 1);
        chk("start_x",   32'(out_x), 0);
        chk("start_y",   32'(out_y), 0);
        chk("start_de_low", 32'(out_de), 0);
        chk("start_fs_popped", 32'(exp_fs.size()), 1);
        tick();
        chk("start_de",  32'(out_de), 1);
        chk("start_x1",  32'(out_x), 1);
        r0 = cyc;

        // Line timing
        wait_for(0, 1'b0, 0, 0, "wait_de_fall");
        f0 = cyc;
        chk("de_width", 32'(f0 - r0), 480);
        wait_for(1, 1'b0, 0, 0, "wait_hs_fall");
        h0 = cyc;
        chk("hs_after_de", 32'(h0 - f0), 2);
        wait_for(1, 1'b1, 0, 0, "wait_hs_rise");
        chk("hs_width", 32'(cyc - h0), 41);
        wait_for(0, 1'b1, 0, 0, "wait_de_rise");
        chk("line_period", 32'(cyc - r0), H_TOT);

        // Frame timing
        wait_for(2, 1'b0, 0, 0, "wait_vs_fall");
        v0 = cyc;
        chk("de_lines", 32'(lines), V_ACT);
        chk("vs_start", 32'(v0 - r0), (V_ACT + 2) * H_TOT);
        wait_for(2, 1'b1, 0, 0, "wait_vs_rise");
        chk("vs_width", 32'(cyc - v0), 10 * H_TOT);
        wait_for(3, 1'b1, 0, 0, "wait_fs2");
        chk("fs2_popped", 32'(exp_fs.size()), 0);

        // Lock loss mid-line
        wait_for(4, 1'b1, 100, 30, "wait_y30");
        c = cyc;
        lock = 1'b0;
        repeat (4) tick();
        chk("loss_de",    32'(out_de), 0);
        chk("loss_req",   32'(out_req), 0);
        chk("loss_hsync", 32'(out_hsync), 1);
        chk("loss_vsync", 32'(out_vsync), 1);
        chk("loss_x",     32'(out_x), 0);
        repeat (6) tick();
        chk("loss_held",  32'(out_req), 0);

        // Re-lock restarts at (0,0)
        c = cyc;
        lock = 1'b1;
        exp_fs.push_back(c + 4);
        wait_for(4, 1'b1, 0, -1, "wait_relock_req");
        chk("relock_cycle", 32'(cyc - c), 4);
        chk("relock_y",     32'(out_y), 0);
        chk("relock_popped", 32'(exp_fs.size()), 0);

`ifdef LCD_TIMING_TEST_PATTERN_EN
        tick();
        chk("rgb_x0", 32'(out_rgb), 32'hFFFF);
        wait_for(4, 1'b1, 300, -1, "wait_x300");
        tick();
        chk("rgb_x300", 32'(out_rgb), 32'hF800);
        wait_for(4, 1'b1, 479, -1, "wait_x479");
        tick();
        chk("rgb_x479", 32'(out_rgb), 32'h0000);
        tick();
        chk("rgb_blank_de", 32'(out_de), 0);
        chk("rgb_blank", 32'(out_rgb), 32'h0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

Generates raster timing for the Tang Nano 9K 480×272 RGB LCD. The block runs in the 9 MHz pixel-clock domain that the PLL clock block produces. Counters start only after the PLL reports lock. The block outputs hsync, vsync and data-enable, plus a pixel-request/address stream one cycle ahead of DE so a registered framebuffer read lines up with the panel.

## Interface
- H_ACTIVE, 480, visible pixels per line
- H_FP, 2, horizontal front porch (clocks)
- H_SYNC, 41, hsync width (clocks)
- H_BP, 2, horizontal back porch (clocks)
- V_ACTIVE, 272, visible lines per frame
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 10, vsync width (lines)
- V_BP, 2, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, sync polarity: 1 = low during sync, high idle

Ports:
- in_clk  in  1  pixel clock, 9 MHz
- in_rst  in  1  asynchronous, active-high reset
- in_clk_lock  in  1  PLL lock, asynchronous to in_clk
- out_req  out  1  pixel request, one cycle before out_de
- out_x  out  HW  column of requested pixel, valid with out_req
- out_y  out  VW  row of requested pixel, valid with out_req
- out_de  out  1  data enable to panel
- out_hsync  out  1  horizontal sync
- out_vsync  out  1  vertical sync
- out_frame_start  out  1  one-cycle pulse on out_req for pixel (0,0)
- out_rgb  out  16  RGB565 test pattern; present only with the test-pattern macro

HW = $clog2(H_TOTAL) and VW = $clog2(V_TOTAL), where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (525) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (286).

## Operation
- **Lock synchronizer:** in_clk_lock passes through a 2-flop synchronizer, giving lock_s.
- **States:**
  - WAIT_LOCK: counters held at 0; all outputs at idle values.
  - RUN: entered on the first cycle with lock_s = 1.
  - In RUN, lock_s = 0 returns the block to WAIT_LOCK the next cycle. Counters reset to 0, so a re-lock always restarts at frame start and never resumes mid-frame.
- **Counters (RUN only):**
  - h_cnt increments every clock and wraps at H_TOTAL-1 → 0.
  - v_cnt increments on each h wrap and wraps at V_TOTAL-1 → 0.
- **Line order:** active [0, H_ACTIVE), then front porch, then sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), then back porch. The vertical axis uses the same order in lines.
- **Request stage (registered from counters):**
  - out_req = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - out_x = h_cnt and out_y = v_cnt while out_req is high; both are 0 otherwise.
  - out_frame_start = (h_cnt == 0 && v_cnt == 0).
- **Output stage:** out_de, out_hsync and out_vsync are the request-stage decodes delayed one further cycle. DE therefore follows REQ by exactly 1 clock.
- **Sync polarity:** sync asserted = !SYNC_ACTIVE_LOW. vsync changes only at the h_cnt = 0 boundary.
- **Reset values:** out_req = 0, out_x = 0, out_y = 0, out_de = 0, out_frame_start = 0, out_rgb = 0. out_hsync and out_vsync reset to the deasserted level (1 when SYNC_ACTIVE_LOW = 1).

## Timing
- Lock latency: in_clk_lock rise → lock_s after 2 clocks → RUN on the next clock → first out_req/out_frame_start 1 clock later, 4 clocks in total.
- Lock loss: idle outputs within 4 clocks.
- REQ→DE latency: 1 clock. hsync/vsync are aligned with DE.
- Line period: 525 clocks. Frame period: 150 150 clocks, which is 59.94 Hz at 9 MHz.
- in_rst asserted mid-frame: all flops return to reset values immediately; the next frame starts from WAIT_LOCK.

## Configuration
- LCD_TIMING_TEST_PATTERN_EN defined:
  - out_rgb port exists.
  - Shows eight vertical colour bars: bar index = out_x / (H_ACTIVE/8).
  - Colours in order: white, yellow, cyan, green, magenta, red, blue, black.
  - out_rgb is registered in the DE stage and is 16'h0000 whenever DE = 0.
- LCD_TIMING_TEST_PATTERN_EN undefined: no out_rgb port and no pattern logic.

## Structure
- Package lcd_timing_pkg holds:
  - default porch/sync/active constants
  - the state enum (WAIT_LOCK, RUN)
  - the eight RGB565 bar colour constants
- Sub-module lock_sync: the 2-flop synchronizer, which takes the async reset and clears to 0.

## Test plan
- **Reset/idle:** in_rst high, in_clk_lock = 1 → out_de = 0, out_hsync = out_vsync = 1, out_req = 0.
- **Lock start:** in_clk_lock rises at cycle t → out_frame_start pulses at t+4 with out_x = 0, out_y = 0; out_de = 1 at t+5.
- **Line timing:**
  - DE high for 480 clocks per line.
  - hsync low for 41 clocks, starting 2 clocks after DE falls.
  - Line period 525.
- **Frame timing:**
  - 272 DE lines, then vsync low for 10 lines starting at line 274.
  - Next out_frame_start occurs 150 150 clocks after the previous one.
- **Lock loss:** drop in_clk_lock mid-line at y = 100 → outputs idle within 4 clocks; on re-lock the next out_req is at (0,0).
- **Test pattern (macro on):**
  - out_x = 0 → out_rgb = 16'hFFFF.
  - out_x = 300 → 16'hF800 (red).
  - out_x = 479 → 16'h0000.
  - During blanking → 16'h0000.
